// File: rtl/apb_exe_requester.sv
// APB requester for the exe unit: writes A, B and CTRL, polls STATUS until done,
// then reads RESULT and reports result plus ALU, bus and timeout flags locally.
module apb_exe_requester #(
  parameter int unsigned      BITS      = 4,
  parameter int unsigned      ADDR_W    = 8,
  parameter int unsigned      DATA_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int unsigned      POLL_MAX  = 15
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              i_start,
  input  logic [3:0]        i_opcode,
  input  logic [BITS-1:0]   i_argA,
  input  logic [BITS-1:0]   i_argB,
  output logic              o_busy,
  output logic              o_valid,
  output logic [BITS-1:0]   o_result,
  output logic              o_error,
  output logic              o_bus_err,
  output logic              o_timeout,
  output logic [ADDR_W-1:0] paddr,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StDone} state_e;
  typedef enum logic [2:0] {StepWrA, StepWrB, StepWrCtrl, StepRdStat, StepRdRes} step_e;

  localparam logic [ADDR_W-1:0] OffA    = ADDR_W'(8'h00);
  localparam logic [ADDR_W-1:0] OffB    = ADDR_W'(8'h04);
  localparam logic [ADDR_W-1:0] OffCtrl = ADDR_W'(8'h08);
  localparam logic [ADDR_W-1:0] OffStat = ADDR_W'(8'h0C);
  localparam logic [ADDR_W-1:0] OffRes  = ADDR_W'(8'h10);
  localparam logic [7:0]        PollMax = 8'(POLL_MAX);

  state_e          state_q, state_d;
  step_e           step_q, step_d;
  logic [3:0]      opcode_q, opcode_d;
  logic [BITS-1:0] arga_q, arga_d;
  logic [BITS-1:0] argb_q, argb_d;
  logic [7:0]      poll_q, poll_d;
  logic [BITS-1:0] result_q, result_d;
  logic            error_q, error_d;
  logic            bus_err_q, bus_err_d;
  logic            timeout_q, timeout_d;

  // Only STATUS[1:0] and RESULT[BITS-1:0] are consumed.
  logic unused_prdata;
  assign unused_prdata = ^prdata;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q   <= StIdle;
      step_q    <= StepWrA;
      opcode_q  <= '0;
      arga_q    <= '0;
      argb_q    <= '0;
      poll_q    <= '0;
      result_q  <= '0;
      error_q   <= 1'b0;
      bus_err_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      opcode_q  <= opcode_d;
      arga_q    <= arga_d;
      argb_q    <= argb_d;
      poll_q    <= poll_d;
      result_q  <= result_d;
      error_q   <= error_d;
      bus_err_q <= bus_err_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    opcode_d  = opcode_q;
    arga_d    = arga_q;
    argb_d    = argb_q;
    poll_d    = poll_q;
    result_d  = result_q;
    error_d   = error_q;
    bus_err_d = bus_err_q;
    timeout_d = timeout_q;
    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          opcode_d  = i_opcode;
          arga_d    = i_argA;
          argb_d    = i_argB;
          step_d    = StepWrA;
          poll_d    = '0;
          error_d   = 1'b0;
          bus_err_d = 1'b0;
          timeout_d = 1'b0;
          state_d   = StSetup;
        end
      end
      StSetup: state_d = StAccess;
      StAccess: begin
        if (pready) begin
          if (pslverr) begin
            bus_err_d = 1'b1;
            state_d   = StDone;
          end else begin
            state_d = StSetup;
            unique case (step_q)
              StepWrA:    step_d = StepWrB;
              StepWrB:    step_d = StepWrCtrl;
              StepWrCtrl: step_d = StepRdStat;
              StepRdStat: begin
                if (prdata[0]) begin
                  error_d = prdata[1];
                  step_d  = StepRdRes;
                end else begin
                  poll_d = poll_q + 8'd1;
                  if (poll_d == PollMax) begin
                    timeout_d = 1'b1;
                    state_d   = StDone;
                  end
                end
              end
              StepRdRes: begin
                result_d = prdata[BITS-1:0];
                state_d  = StDone;
              end
              default: state_d = StDone;
            endcase
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Bus address/data derive purely from the step register, so they hold across wait states.
  always_comb begin
    paddr  = BASE_ADDR + OffA;
    pwrite = 1'b0;
    pwdata = '0;
    unique case (step_q)
      StepWrA: begin
        paddr  = BASE_ADDR + OffA;
        pwrite = 1'b1;
        pwdata = {{(DATA_W-BITS){arga_q[BITS-1]}}, arga_q};
      end
      StepWrB: begin
        paddr  = BASE_ADDR + OffB;
        pwrite = 1'b1;
        pwdata = {{(DATA_W-BITS){argb_q[BITS-1]}}, argb_q};
      end
      StepWrCtrl: begin
        paddr     = BASE_ADDR + OffCtrl;
        pwrite    = 1'b1;
        pwdata[8] = 1'b1;
        pwdata[3:0] = opcode_q;
      end
      StepRdStat: paddr = BASE_ADDR + OffStat;
      StepRdRes:  paddr = BASE_ADDR + OffRes;
      default:    paddr = BASE_ADDR + OffA;
    endcase
  end

  assign psel      = (state_q == StSetup) || (state_q == StAccess);
  assign penable   = (state_q == StAccess);
  assign o_busy    = (state_q != StIdle);
  assign o_valid   = (state_q == StDone);
  assign o_result  = result_q;
  assign o_error   = error_q;
  assign o_bus_err = bus_err_q;
  assign o_timeout = timeout_q;

endmodule

// File: tb/tb_apb_exe_requester.sv
// Bench for apb_exe_requester: behavioural APB slave plus scoreboards of expected
// transfers and expected command results.
module tb_apb_exe_requester;
  localparam int BITS = 4;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int POLL_MAX = 15;
  localparam logic [3:0] OP_NEG = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h1;

  logic pclk = 1'b0;
  logic presetn = 1'b0;
  logic i_start = 1'b0;
  logic [3:0] i_opcode = '0;
  logic [BITS-1:0] i_argA = '0, i_argB = '0;
  logic o_busy, o_valid, o_error, o_bus_err, o_timeout;
  logic [BITS-1:0] o_result;
  logic [ADDR_W-1:0] paddr;
  logic psel, penable, pwrite;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata = '0;
  logic pready = 1'b0, pslverr = 1'b0;

  apb_exe_requester #(
    .BITS(BITS), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BASE_ADDR(8'h00), .POLL_MAX(POLL_MAX)
  ) dut (
    .pclk(pclk), .presetn(presetn), .i_start(i_start), .i_opcode(i_opcode),
    .i_argA(i_argA), .i_argB(i_argB), .o_busy(o_busy), .o_valid(o_valid),
    .o_result(o_result), .o_error(o_error), .o_bus_err(o_bus_err), .o_timeout(o_timeout),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  typedef struct { logic [7:0] addr; logic wr; logic [31:0] data; } xfer_t;
  typedef struct { logic [3:0] result; logic error; logic bus_err; logic timeout; int lat; } res_t;
  xfer_t exp_xfer[$];
  res_t  exp_res[$];

  // Slave configuration
  logic [7:0]  ws_addr = '0;
  int          ws_n = 0;
  bit          ws_armed = 0;
  logic [7:0]  err_addr = '0;
  bit          err_en = 0;
  int          stat_zero_n = 0;
  logic [31:0] stat_val = 32'h1;
  logic [31:0] res_val = '0;
  int          stat_reads = 0;
  bit          chk_xfer = 1;
  logic [3:0]  last_result = '0;

  int          wait_left = 0;
  logic [7:0]  cap_addr = '0;
  logic [31:0] cap_wdata = '0;
  logic        prev_psel = 1'b0, prev_pen = 1'b0;

  task automatic log_xfer(input logic [7:0] a, input logic w, input logic [31:0] d);
    xfer_t e;
    if (!chk_xfer) return;
    if (exp_xfer.size() == 0) begin
      check("xfer_unexpected_addr", {24'h0, a}, 32'hFFFF_FFFF);
      return;
    end
    e = exp_xfer.pop_front();
    check("xfer_addr", {24'h0, a}, {24'h0, e.addr});
    check("xfer_dir", {31'h0, w}, {31'h0, e.wr});
    if (e.wr) check("xfer_wdata", d, e.data);
  endtask

  // APB slave: decisions made on the falling edge, handshake completes on the next rising edge.
  always @(negedge pclk) begin
    if (!presetn) begin
      pready = 1'b0; pslverr = 1'b0; wait_left = 0;
      prev_psel = 1'b0; prev_pen = 1'b0;
    end else begin
      if (penable && !prev_pen) check("penable_after_setup", {31'h0, prev_psel}, 32'h1);
      if (penable) check("penable_needs_psel", {31'h0, psel}, 32'h1);
      prev_psel = psel;
      prev_pen  = penable;
      if (psel && !penable) begin
        pready = 1'b0; pslverr = 1'b0;
        cap_addr = paddr; cap_wdata = pwdata;
        if (ws_armed && paddr == ws_addr) begin
          wait_left = ws_n; ws_armed = 0;
        end else wait_left = 0;
      end else if (psel && penable) begin
        if (wait_left > 0) begin
          check("hold_addr", {24'h0, paddr}, {24'h0, cap_addr});
          check("hold_wdata", pwdata, cap_wdata);
          wait_left--;
          pready = 1'b0;
        end else begin
          pready  = 1'b1;
          pslverr = err_en && (paddr == err_addr);
          prdata  = '0;
          if (!pwrite && paddr == 8'h0C) begin
            prdata = (stat_reads < stat_zero_n) ? 32'h0 : stat_val;
            stat_reads++;
          end else if (!pwrite && paddr == 8'h10) prdata = res_val;
          log_xfer(paddr, pwrite, pwdata);
        end
      end else begin
        pready = 1'b0; pslverr = 1'b0;
      end
    end
  end

  task automatic run_cmd(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                         input int n_stat, input bit reach_res, input bit bus_err, input bit to,
                         input int ws, input bit poke);
    res_t r;
    xfer_t x;
    int t0, nx;
    bit seen;
    stat_reads = 0;
    x.addr = 8'h00; x.wr = 1'b1; x.data = {{28{a[3]}}, a}; exp_xfer.push_back(x);
    x.addr = 8'h04; x.wr = 1'b1; x.data = {{28{b[3]}}, b}; exp_xfer.push_back(x);
    x.addr = 8'h08; x.wr = 1'b1; x.data = 32'h100 | {28'h0, op}; exp_xfer.push_back(x);
    nx = 3;
    if (!bus_err) begin
      for (int i = 0; i < n_stat; i++) begin
        x.addr = 8'h0C; x.wr = 1'b0; x.data = '0; exp_xfer.push_back(x);
      end
      nx += n_stat;
      if (reach_res) begin
        x.addr = 8'h10; x.wr = 1'b0; x.data = '0; exp_xfer.push_back(x);
        nx++;
      end
    end
    r.result  = (reach_res && !bus_err) ? res_val[3:0] : last_result;
    r.error   = (reach_res && !bus_err) ? stat_val[1] : 1'b0;
    r.bus_err = bus_err;
    r.timeout = to;
    r.lat     = 1 + 2 * nx + ws;
    last_result = r.result;
    exp_res.push_back(r);

    @(negedge pclk);
    i_opcode = op; i_argA = a; i_argB = b; i_start = 1'b1;
    t0 = cyc;
    @(negedge pclk);
    i_start = 1'b0;
    seen = 0;
    for (int k = 0; k < 300; k++) begin
      if (o_valid) begin seen = 1; break; end
      i_start = poke && (k == 3);
      @(negedge pclk);
    end
    i_start = 1'b0;
    r = exp_res.pop_front();
    if (!seen) check("valid_never_seen", 32'h0, 32'h1);
    else begin
      check("latency", cyc - t0, r.lat);
      check("result", {28'h0, o_result}, {28'h0, r.result});
      check("error", {31'h0, o_error}, {31'h0, r.error});
      check("bus_err", {31'h0, o_bus_err}, {31'h0, r.bus_err});
      check("timeout", {31'h0, o_timeout}, {31'h0, r.timeout});
      check("busy_in_done", {31'h0, o_busy}, 32'h1);
      check("psel_in_done", {31'h0, psel}, 32'h0);
    end
    @(negedge pclk);
    check("valid_one_cycle", {31'h0, o_valid}, 32'h0);
    check("busy_idle", {31'h0, o_busy}, 32'h0);
    check("xfers_remaining", exp_xfer.size(), 0);
    exp_xfer.delete();
    @(negedge pclk);
    check("stays_idle", {31'h0, o_busy}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit hit;
    repeat (3) @(negedge pclk);
    check("rst_psel", {31'h0, psel}, 32'h0);
    check("rst_penable", {31'h0, penable}, 32'h0);
    check("rst_busy", {31'h0, o_busy}, 32'h0);
    check("rst_valid", {31'h0, o_valid}, 32'h0);
    check("rst_result", {28'h0, o_result}, 32'h0);
    presetn = 1'b1;
    @(negedge pclk);

    // Negation, with a stray start mid-command that must be ignored
    stat_val = 32'h1; res_val = 32'hD; stat_zero_n = 0;
    run_cmd(OP_NEG, 4'h3, 4'h0, 1, 1, 0, 0, 0, 1);

    // Negation overflow
    stat_val = 32'h3; res_val = 32'h8;
    run_cmd(OP_NEG, 4'h8, 4'h0, 1, 1, 0, 0, 0, 0);

    // Wait states on WR_B and two not-done polls
    stat_val = 32'h1; res_val = 32'h5; stat_zero_n = 2;
    ws_addr = 8'h04; ws_n = 3; ws_armed = 1;
    run_cmd(OP_ADD, 4'h2, 4'h3, 3, 1, 0, 0, 3, 0);

    // Slave error on CTRL aborts before any read
    stat_zero_n = 0; err_addr = 8'h08; err_en = 1;
    run_cmd(OP_ADD, 4'h1, 4'h1, 0, 0, 1, 0, 0, 0);
    err_en = 0;

    // STATUS never done
    stat_zero_n = 1000;
    run_cmd(OP_NEG, 4'h1, 4'h0, POLL_MAX, 0, 0, 1, 0, 0);

    // Reset during a STATUS access
    chk_xfer = 0; stat_reads = 0;
    @(negedge pclk);
    i_opcode = OP_NEG; i_argA = 4'h4; i_start = 1'b1;
    @(negedge pclk);
    i_start = 1'b0;
    hit = 0;
    for (int k = 0; k < 100; k++) begin
      if (psel && penable && paddr == 8'h0C) begin hit = 1; break; end
      @(negedge pclk);
    end
    check("reached_stat_access", {31'h0, hit}, 32'h1);
    #2 presetn = 1'b0;
    #1;
    check("arst_psel", {31'h0, psel}, 32'h0);
    check("arst_penable", {31'h0, penable}, 32'h0);
    check("arst_busy", {31'h0, o_busy}, 32'h0);
    check("arst_timeout", {31'h0, o_timeout}, 32'h0);
    check("arst_result", {28'h0, o_result}, 32'h0);
    repeat (2) @(negedge pclk);
    check("arst_no_valid", {31'h0, o_valid}, 32'h0);
    presetn = 1'b1;
    last_result = '0;
    chk_xfer = 1;
    exp_xfer.delete();
    @(negedge pclk);

    stat_zero_n = 0; stat_val = 32'h1; res_val = 32'h2;
    run_cmd(OP_NEG, 4'hE, 4'h0, 1, 1, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
